// File: rtl/fm_slot_scheduler.sv
// Shared FM operator slot scheduler: issues (channel, operator) slots per sample tick, sums carrier results, commits offset-binary samples.
// Optional build macro FM_SCHED_MUTE_EN adds mute_i (per-channel slot skipping, muted lanes commit 12'h800).
module fm_slot_scheduler #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned NUM_OP = 4,
  parameter int unsigned RES_W  = 12
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        sample_tick_i,
  input  logic [NUM_CH*NUM_OP-1:0]    carrier_mask_i,
  output logic                        slot_valid_o,
  input  logic                        slot_ready_i,
  output logic [$clog2(NUM_CH)-1:0]   slot_ch_o,
  output logic [$clog2(NUM_OP)-1:0]   slot_op_o,
  input  logic                        res_valid_i,
  input  logic [$clog2(NUM_CH)-1:0]   res_ch_i,
  input  logic [$clog2(NUM_OP)-1:0]   res_op_i,
  input  logic signed [RES_W-1:0]     res_data_i,
  output logic [NUM_CH*12-1:0]        sample_o,
  output logic                        frame_done_o,
  output logic                        busy_o,
  output logic                        overrun_o
`ifdef FM_SCHED_MUTE_EN
  ,
  input  logic [NUM_CH-1:0]           mute_i
`endif
);

  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned OP_W  = $clog2(NUM_OP);
  localparam int unsigned ACC_W = RES_W + OP_W;
  localparam int unsigned CNT_W = $clog2(NUM_CH*NUM_OP) + 1;
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2047);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-2048);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_COMMIT} state_t;

  state_t                   state;
  logic [NUM_CH*NUM_OP-1:0] mask_q;
  logic [NUM_CH-1:0]        mute_q;
  logic [NUM_CH-1:0]        start_mute;
  logic [CNT_W-1:0]         res_cnt;
  logic [CNT_W-1:0]         exp_cnt;
  logic signed [ACC_W-1:0]  acc [NUM_CH];
  logic [11:0]              commit_val [NUM_CH];
  logic [CH_W-1:0]          first_ch, next_ch;
  logic                     first_found, next_found;

`ifdef FM_SCHED_MUTE_EN
  assign start_mute = mute_i;
`else
  assign start_mute = '0;
  assign mute_q     = '0;
`endif

  // Channel sequencing skips muted channels; without the mute build every channel is live.
  always_comb begin
    first_ch    = '0;
    first_found = 1'b0;
    next_ch     = '0;
    next_found  = 1'b0;
    exp_cnt     = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (!first_found && !start_mute[c]) begin
        first_ch    = CH_W'(c);
        first_found = 1'b1;
      end
      if (!next_found && (c > 32'(slot_ch_o)) && !mute_q[c]) begin
        next_ch    = CH_W'(c);
        next_found = 1'b1;
      end
      if (!mute_q[c]) exp_cnt = exp_cnt + CNT_W'(NUM_OP);
    end
  end

  // Saturate to 12-bit signed, then flip the MSB to get offset binary.
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (mute_q[c])             commit_val[c] = 12'h800;
      else if (acc[c] > SAT_HI)  commit_val[c] = 12'hFFF;
      else if (acc[c] < SAT_LO)  commit_val[c] = 12'h000;
      else                       commit_val[c] = acc[c][11:0] ^ 12'h800;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      slot_valid_o <= 1'b0;
      slot_ch_o    <= '0;
      slot_op_o    <= '0;
      sample_o     <= {NUM_CH{12'h800}};
      frame_done_o <= 1'b0;
      busy_o       <= 1'b0;
      overrun_o    <= 1'b0;
      mask_q       <= '0;
      res_cnt      <= '0;
`ifdef FM_SCHED_MUTE_EN
      mute_q       <= '0;
`endif
      for (int unsigned c = 0; c < NUM_CH; c++) acc[c] <= '0;
    end else begin
      frame_done_o <= 1'b0;
      if (sample_tick_i && state != S_IDLE) overrun_o <= 1'b1;

      if ((state == S_ISSUE || state == S_DRAIN) && res_valid_i) begin
        res_cnt <= res_cnt + 1'b1;
        if (mask_q[{res_ch_i, res_op_i}])
          acc[res_ch_i] <= acc[res_ch_i] + ACC_W'(res_data_i);
      end

      case (state)
        S_IDLE: begin
          if (sample_tick_i) begin
            state        <= first_found ? S_ISSUE : S_COMMIT;
            mask_q       <= carrier_mask_i;
`ifdef FM_SCHED_MUTE_EN
            mute_q       <= mute_i;
`endif
            res_cnt      <= '0;
            busy_o       <= 1'b1;
            slot_valid_o <= first_found;
            slot_ch_o    <= first_ch;
            slot_op_o    <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) acc[c] <= '0;
          end
        end
        S_ISSUE: begin
          if (slot_ready_i) begin
            if (slot_op_o == OP_W'(NUM_OP - 1)) begin
              slot_op_o <= '0;
              if (next_found) begin
                slot_ch_o <= next_ch;
              end else begin
                slot_valid_o <= 1'b0;
                state        <= S_DRAIN;
              end
            end else begin
              slot_op_o <= slot_op_o + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (res_cnt == exp_cnt) state <= S_COMMIT;
        end
        S_COMMIT: begin
          for (int unsigned c = 0; c < NUM_CH; c++) sample_o[c*12 +: 12] <= commit_val[c];
          frame_done_o <= 1'b1;
          busy_o       <= 1'b0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fm_slot_scheduler.sv
// Bench for fm_slot_scheduler: randomized slot handshakes and results against a per-frame sum/clamp model.
module tb_fm_slot_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        sample_tick_i = 1'b0;
  logic [15:0] carrier_mask_i = '0;
  logic        slot_valid_o;
  logic        slot_ready_i = 1'b0;
  logic [1:0]  slot_ch_o;
  logic [1:0]  slot_op_o;
  logic        res_valid_i = 1'b0;
  logic [1:0]  res_ch_i = '0;
  logic [1:0]  res_op_i = '0;
  logic [11:0] res_data_i = '0;
  logic [47:0] sample_o;
  logic        frame_done_o;
  logic        busy_o;
  logic        overrun_o;
`ifdef FM_SCHED_MUTE_EN
  logic [3:0]  mute_i = '0;
`endif

  int checks = 0;
  int errors = 0;
  int data_tbl [16];

  always #5 clk_i = ~clk_i;

  fm_slot_scheduler #(.NUM_CH(4), .NUM_OP(4), .RES_W(12)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .sample_tick_i(sample_tick_i),
    .carrier_mask_i(carrier_mask_i), .slot_valid_o(slot_valid_o),
    .slot_ready_i(slot_ready_i), .slot_ch_o(slot_ch_o), .slot_op_o(slot_op_o),
    .res_valid_i(res_valid_i), .res_ch_i(res_ch_i), .res_op_i(res_op_i),
    .res_data_i(res_data_i), .sample_o(sample_o), .frame_done_o(frame_done_o),
    .busy_o(busy_o), .overrun_o(overrun_o)
`ifdef FM_SCHED_MUTE_EN
    , .mute_i(mute_i)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_lanes_reset(input string tag);
    for (int c = 0; c < 4; c++) chk(tag, 64'(sample_o[c*12 +: 12]), 64'h800);
  endtask

  // One frame: model = per-channel sum of carrier results, clamped, +2048; muted lanes 12'h800.
  task automatic run_frame(input logic [15:0] mask, input logic [3:0] mute,
                           input int lat_min, input int lat_max, input bit rnd_ready,
                           input bit extra_tick, input bit exp_ovr);
    int exp_ch[$], exp_op[$];
    int pend_due[$], pend_ch[$], pend_op[$];
    int issued = 0, returned = 0, dones = 0, done_cyc = -1;
    int first_acc = -1, last_acc = -1, n_exp, sum;
    bit pv = 1'b0, pr = 1'b0, ticked = 1'b0;
    int pch = 0, pop = 0;
    logic [11:0] expv [4];

    for (int ch = 0; ch < 4; ch++) begin
      sum = 0;
      for (int op = 0; op < 4; op++) if (mask[ch*4+op]) sum += data_tbl[ch*4+op];
      if (sum > 2047) sum = 2047;
      if (sum < -2048) sum = -2048;
      expv[ch] = mute[ch] ? 12'h800 : 12'(sum + 2048);
      if (!mute[ch]) for (int op = 0; op < 4; op++) begin
        exp_ch.push_back(ch);
        exp_op.push_back(op);
      end
    end
    n_exp = exp_ch.size();

    @(negedge clk_i);
    sample_tick_i  = 1'b1;
    carrier_mask_i = mask;
`ifdef FM_SCHED_MUTE_EN
    mute_i = mute;
`endif
    slot_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    pr = slot_ready_i;

    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk_i);
      sample_tick_i  = 1'b0;
      res_valid_i    = 1'b0;
      carrier_mask_i = 16'($urandom);
      if (cyc == 1) chk("busy_in_frame", 64'(busy_o), 64'(1));
      if (pv && !pr) begin
        chk("hold_valid", 64'(slot_valid_o), 64'(1));
        chk("hold_ch", 64'(slot_ch_o), 64'(pch));
        chk("hold_op", 64'(slot_op_o), 64'(pop));
      end
      if (frame_done_o) begin
        dones++;
        if (dones == 1) begin
          done_cyc = cyc;
          chk("results_before_done", 64'(returned), 64'(n_exp));
          for (int c = 0; c < 4; c++) chk("lane", 64'(sample_o[c*12 +: 12]), 64'(expv[c]));
        end
      end
      if (extra_tick && !ticked && n_exp > 0 && issued == n_exp && dones == 0) begin
        sample_tick_i = 1'b1;
        ticked = 1'b1;
      end
      for (int i = 0; i < pend_due.size(); i++) begin
        if (pend_due[i] <= cyc) begin
          res_valid_i = 1'b1;
          res_ch_i    = 2'(pend_ch[i]);
          res_op_i    = 2'(pend_op[i]);
          res_data_i  = 12'(data_tbl[pend_ch[i]*4 + pend_op[i]]);
          pend_due.delete(i); pend_ch.delete(i); pend_op.delete(i);
          returned++;
          break;
        end
      end
      slot_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (slot_valid_o && slot_ready_i) begin
        if (exp_ch.size() == 0) begin
          chk("slot_count", 64'(issued + 1), 64'(n_exp));
        end else begin
          chk("slot_ch", 64'(slot_ch_o), 64'(exp_ch.pop_front()));
          chk("slot_op", 64'(slot_op_o), 64'(exp_op.pop_front()));
        end
        pend_due.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
        pend_ch.push_back(int'(slot_ch_o));
        pend_op.push_back(int'(slot_op_o));
        issued++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
      pv = slot_valid_o; pr = slot_ready_i;
      pch = int'(slot_ch_o); pop = int'(slot_op_o);
      if (dones > 0 && cyc >= done_cyc + 4) break;
    end
    res_valid_i = 1'b0;
    chk("done_count", 64'(dones), 64'(1));
    chk("issued", 64'(issued), 64'(n_exp));
    if (!rnd_ready && n_exp > 0) chk("back_to_back", 64'(last_acc - first_acc), 64'(n_exp - 1));
    if (n_exp == 0) chk("mute_all_latency", 64'(done_cyc), 64'(2));
    chk("busy_after", 64'(busy_o), 64'(0));
    chk("valid_after", 64'(slot_valid_o), 64'(0));
    chk("overrun", 64'(overrun_o), 64'(exp_ovr));
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk_i);
    chk("rst_valid", 64'(slot_valid_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_done", 64'(frame_done_o), 64'(0));
    chk("rst_overrun", 64'(overrun_o), 64'(0));
    chk("rst_ch", 64'(slot_ch_o), 64'(0));
    chk_lanes_reset("rst_lane");
    rst_i = 1'b0;
    @(negedge clk_i);

    // Directed summing / saturation, carriers = ops 2,3, ready held, latency 3
    for (int i = 0; i < 16; i++) data_tbl[i] = 1234;
    data_tbl[2]  = 1000;  data_tbl[3]  = 500;
    data_tbl[6]  = 2000;  data_tbl[7]  = 2000;
    data_tbl[10] = -2048; data_tbl[11] = -100;
    data_tbl[14] = 7;     data_tbl[15] = -9;
    run_frame(16'hCCCC, 4'b0000, 3, 3, 1'b0, 1'b0, 1'b0);
    chk("lane0_ddc", 64'(sample_o[11:0]), 64'hDDC);

    // Reset asserted mid-ISSUE
    @(negedge clk_i);
    sample_tick_i = 1'b1;
    slot_ready_i  = 1'b0;
    @(negedge clk_i);
    sample_tick_i = 1'b0;
    chk("issue_valid", 64'(slot_valid_o), 64'(1));
    rst_i = 1'b1;
    #1;
    chk("midrst_valid", 64'(slot_valid_o), 64'(0));
    chk("midrst_busy", 64'(busy_o), 64'(0));
    chk("midrst_done", 64'(frame_done_o), 64'(0));
    chk_lanes_reset("midrst_lane");
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("postrst_done", 64'(frame_done_o), 64'(0));
    chk("postrst_busy", 64'(busy_o), 64'(0));

    // Randomized frames with backpressure and varying latency
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 16; i++) data_tbl[i] = int'($urandom_range(0, 4095)) - 2048;
      run_frame(16'($urandom), 4'b0000, 1, 6, 1'b1, 1'b0, 1'b0);
    end

    // Overrun: extra tick during DRAIN, then a normal frame
    for (int i = 0; i < 16; i++) data_tbl[i] = int'($urandom_range(0, 1023)) - 512;
    run_frame(16'hFFFF, 4'b0000, 2, 5, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) data_tbl[i] = int'($urandom_range(0, 4095)) - 2048;
    run_frame(16'($urandom), 4'b0000, 1, 4, 1'b1, 1'b0, 1'b1);

`ifdef FM_SCHED_MUTE_EN
    for (int i = 0; i < 16; i++) data_tbl[i] = int'($urandom_range(0, 1023)) - 512;
    run_frame(16'hFFFF, 4'b0010, 1, 4, 1'b1, 1'b0, 1'b1);
    run_frame(16'hFFFF, 4'b1111, 1, 4, 1'b0, 1'b0, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fm_slot_scheduler.md
Name: fm_slot_scheduler

Overview:
- Time-multiplexes one shared FM operator datapath across NUM_CH channels × NUM_OP operators.
- On each sample tick, issues every (channel, operator) slot to the datapath over a valid/ready handshake.
- Collects the datapath results and sums the carrier outputs per channel.
- Commits one 12-bit offset-binary sample per channel; these are the sources for the sample_raw outputs of the FM top level.

Parameters:
- NUM_CH, 4, channels sequenced per frame (power of two, ≥2).
- NUM_OP, 4, operators per channel (power of two, ≥2).
- RES_W, 12, signed width of the datapath result.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous reset, active-high.
- sample_tick_i  in  1  one-cycle strobe that starts a frame.
- carrier_mask_i  in  NUM_CH*NUM_OP  bit (ch*NUM_OP+op) set = that operator's output is summed into the channel sample.
- slot_valid_o  out  1  slot request to the datapath.
- slot_ready_i  in  1  datapath accepts the slot.
- slot_ch_o  out  log2(NUM_CH)  channel index of the issued slot.
- slot_op_o  out  log2(NUM_OP)  operator index of the issued slot.
- res_valid_i  in  1  datapath result strobe.
- res_ch_i  in  log2(NUM_CH)  channel tag of the result.
- res_op_i  in  log2(NUM_OP)  operator tag of the result.
- res_data_i  in  RES_W  signed two's-complement operator output.
- sample_o  out  NUM_CH*12  committed samples, offset binary, channel 0 in the LSBs.
- frame_done_o  out  1  one-cycle pulse when sample_o updates.
- busy_o  out  1  high while a frame is in progress.
- overrun_o  out  1  sticky; set when a tick arrives while busy.
- mute_i  in  NUM_CH  present only with FM_SCHED_MUTE_EN.

Behaviour:
- Reset (async): state=IDLE, slot_valid_o=0, slot_ch_o=0, slot_op_o=0, every sample_o lane=12'h800, frame_done_o=0, busy_o=0, overrun_o=0, accumulators=0, counters=0.
- Reset asserted mid-frame aborts the frame immediately. No commit happens; sample_o returns to 12'h800.
- States:
  - IDLE: on sample_tick_i → ISSUE. In the same edge, clear accumulators and the issue and result counters, and snapshot carrier_mask_i; the snapshot is used for the whole frame. Set busy_o.
  - ISSUE: slot_valid_o=1. slot_ch_o/slot_op_o are held stable until slot_valid_o && slot_ready_i.
    - Issue order is channel-major: (0,0),(0,1)…(0,NUM_OP-1),(1,0)…
    - The last slot accepted → DRAIN. slot_valid_o drops the next cycle.
    - slot_valid_o never deasserts without acceptance.
  - DRAIN: wait until the result counter = NUM_CH*NUM_OP → COMMIT.
  - COMMIT (1 cycle):
    - Load sample_o for every lane.
    - Pulse frame_done_o.
    - Clear busy_o → IDLE.
- Results may arrive during ISSUE or DRAIN, tagged by res_ch_i/res_op_i, at most one per cycle, in any latency ≥1 cycle after acceptance.
  - Each res_valid_i increments the result counter.
  - If the snapshot mask bit is set, res_data_i is sign-extended and added to that channel's accumulator.
- Arithmetic:
  - Accumulator width RES_W+log2(NUM_OP) signed; no internal overflow is possible.
  - Commit value per channel = clamp(acc, −2048, +2047) + 2048, giving 12 bits offset binary.
- res_valid_i while IDLE is ignored. It does not count or accumulate, and it does not set overrun.
- sample_tick_i when state≠IDLE sets overrun_o (sticky until reset). The tick is dropped; the frame in progress is unaffected.
- A tick in the same cycle as COMMIT counts as busy.
- Maximum throughput: a back-to-back accepted slot every cycle.
- Minimum frame = NUM_CH*NUM_OP issue cycles + drain + 1 commit cycle.

Optional Feature:
- FM_SCHED_MUTE_EN defined:
  - Adds port mute_i, snapshotted at frame start.
  - Slots of muted channels are skipped: not issued, and excluded from the expected result count.
  - A muted channel commits 12'h800.
  - If all channels are muted, the frame goes IDLE → COMMIT directly, 2 cycles after the tick.
- Undefined: the port is absent and all channels are always sequenced.

Test Plan:
- Reset values: assert rst_i mid-ISSUE → next cycle slot_valid_o=0, busy_o=0, all sample_o lanes=12'h800, no frame_done_o.
- Issue order and latency: slot_ready_i held 1, results returned 3 cycles after acceptance → 16 slots issued on consecutive cycles in order (0,0)…(3,3); frame_done_o pulses exactly once, after the 16th result.
- Backpressure: slot_ready_i toggled randomly → slot_ch_o/slot_op_o stable while valid && !ready; no slot skipped or duplicated.
- Summing and saturation, carrier mask = ops 2,3 only:
  - ch0 results 1000 and 500 → 1500 → sample 12'h DDC.
  - ch1 results 2000 and 2000 → 4000 → clamps to 2047 → 12'hFFF.
  - ch2 results −2048 and −100 → clamps to −2048 → 12'h000.
  - Non-carrier results of 1234 are ignored.
- Overrun: second sample_tick_i during DRAIN → overrun_o=1 and stays 1; exactly one frame_done_o; the next tick after IDLE starts a normal frame.
- FM_SCHED_MUTE_EN: mute_i=4'b0010 → only 12 slots issued, ch1 lane=12'h800; mute_i=4'b1111 → frame_done_o 2 cycles after the tick with zero slots issued.
